// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle RV64I control unit: decode, sequencing, branch resolve, instret
module control_fsm #(
   parameter int CNT_W           = 64,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      insn,
   input  logic [2:0]       flags_value,
   output logic             load_ins,
   output logic             load_imm,
   output logic             load_rs1,
   output logic             load_rs2,
   output logic             load_alu,
   output logic             load_pc_alu,
   output logic             load_data_memory,
   output logic             load_flags,
   output logic             load_regfile,
   output logic             load_pc,
   output logic             write_mem,
   output logic             sel_pc_next,
   output logic             sel_pc_alu,
   output logic             sel_alu_a,
   output logic             sel_alu_b,
   output logic [1:0]       sel_rd,
   output logic [1:0]       sel_mem_size,
   output logic [2:0]       sel_mem_extension,
   output logic [2:0]       func3,
   output logic             sub_sra,
   output logic [4:0]       rd_addr,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [31:0]      code,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM_RD,
      S_LOAD_WB,
      S_MEM_WR,
      S_WB,
      S_BR_RES,
      S_HALT
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   state_t state, state_next;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic is_load, is_store, is_op, is_op_imm, is_branch;
   logic is_jal, is_jalr, is_auipc, is_lui, is_legal;
   logic flag_eq, flag_ls, flag_lu, taken;

   logic en_ins, en_imm, en_rs1, en_rs2, en_alu, en_pc_alu;
   logic en_data_memory, en_flags, en_regfile, en_pc, en_write_mem, in_halt;

   // insn[31] and insn[29:25] only matter to the immediate generator in the datapath
   logic unused_insn_bits;
   assign unused_insn_bits = ^{insn[31], insn[29:25]};

   assign opcode   = insn[6:0];
   assign f3       = insn[14:12];
   assign rd_addr  = insn[11:7];
   assign rs1_addr = insn[19:15];
   assign rs2_addr = insn[24:20];

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_op     = (opcode == OPC_OP);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_lui    = (opcode == OPC_LUI);
   assign is_legal  = is_load | is_store | is_op | is_op_imm | is_branch
                    | is_jal | is_jalr | is_auipc | is_lui;

   assign flag_eq = flags_value[2];
   assign flag_ls = flags_value[1];
   assign flag_lu = flags_value[0];

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:  taken = flag_eq;
         3'b001:  taken = ~flag_eq;
         3'b100:  taken = flag_ls;
         3'b101:  taken = ~flag_ls;
         3'b110:  taken = flag_lu;
         3'b111:  taken = ~flag_lu;
         default: taken = 1'b0;
      endcase
   end

   // one-hot immediate format {J,U,B,S,I}; R-type and unknown opcodes carry no immediate
   always_comb begin
      code    = '0;
      code[0] = is_load | is_op_imm | is_jalr;
      code[1] = is_store;
      code[2] = is_branch;
      code[3] = is_lui | is_auipc;
      code[4] = is_jal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         instret <= '0;
      end else begin
         state <= state_next;
         if (load_pc)
            instret <= instret + CNT_W'(1);
      end
   end

   always_comb begin
      state_next        = state;
      en_ins            = 1'b0;
      en_imm            = 1'b0;
      en_rs1            = 1'b0;
      en_rs2            = 1'b0;
      en_alu            = 1'b0;
      en_pc_alu         = 1'b0;
      en_data_memory    = 1'b0;
      en_flags          = 1'b0;
      en_regfile        = 1'b0;
      en_pc             = 1'b0;
      en_write_mem      = 1'b0;
      in_halt           = 1'b0;
      sel_pc_next       = 1'b0;
      sel_pc_alu        = 1'b0;
      sel_alu_a         = 1'b0;
      sel_alu_b         = 1'b0;
      sel_rd            = 2'd0;
      sel_mem_size      = 2'd0;
      sel_mem_extension = 3'd0;
      func3             = 3'd0;
      sub_sra           = 1'b0;

      case (state)
         S_FETCH: begin
            en_ins     = 1'b1;
            en_pc_alu  = 1'b1;
            state_next = S_DECODE;
         end

         S_DECODE: begin
            en_imm = 1'b1;
            en_rs1 = 1'b1;
            en_rs2 = 1'b1;
            if (is_lui)
               state_next = S_WB;
            else if (!is_legal)
               state_next = HALT_ON_ILLEGAL ? S_HALT : S_WB;
            else
               state_next = S_EXEC;
         end

         S_EXEC: begin
            en_alu     = 1'b1;
            state_next = S_WB;
            if (is_op) begin
               func3   = f3;
               sub_sra = insn[30];
            end else if (is_op_imm) begin
               sel_alu_b = 1'b1;
               func3     = f3;
               sub_sra   = (f3 == 3'b101) ? insn[30] : 1'b0;
            end else if (is_jal || is_auipc) begin
               sel_alu_a = 1'b1;
               sel_alu_b = 1'b1;
            end else if (is_branch) begin
               en_alu     = 1'b0;
               en_flags   = 1'b1;
               state_next = S_BR_RES;
            end else begin
               sel_alu_b = 1'b1;
               if (is_load)
                  state_next = S_MEM_RD;
               else if (is_store)
                  state_next = S_MEM_WR;
            end
         end

         S_MEM_RD: begin
            en_data_memory = 1'b1;
            sel_mem_size   = f3[1:0];
            state_next     = S_LOAD_WB;
         end

         S_LOAD_WB: begin
            en_regfile        = 1'b1;
            en_pc             = 1'b1;
            sel_mem_size      = f3[1:0];
            sel_mem_extension = f3;
            state_next        = S_FETCH;
         end

         S_MEM_WR: begin
            en_write_mem = 1'b1;
            en_pc        = 1'b1;
            sel_mem_size = f3[1:0];
            state_next   = S_FETCH;
         end

         S_WB: begin
            en_pc      = 1'b1;
            en_regfile = is_legal;
            state_next = S_FETCH;
            if (is_lui)
               sel_rd = 2'd1;
            else if (is_op || is_op_imm || is_auipc)
               sel_rd = 2'd2;
            else if (is_jal || is_jalr) begin
               sel_rd      = 2'd3;
               sel_pc_next = 1'b1;
            end
         end

         S_BR_RES: begin
            en_pc      = 1'b1;
            sel_pc_alu = taken;
            state_next = S_FETCH;
         end

         S_HALT: begin
            in_halt    = 1'b1;
            state_next = S_HALT;
         end

         default: state_next = S_FETCH;
      endcase
   end

   // reset suppresses every side effect in the same cycle, so an interrupted store never lands
   assign load_ins         = en_ins & ~reset;
   assign load_imm         = en_imm & ~reset;
   assign load_rs1         = en_rs1 & ~reset;
   assign load_rs2         = en_rs2 & ~reset;
   assign load_alu         = en_alu & ~reset;
   assign load_pc_alu      = en_pc_alu & ~reset;
   assign load_data_memory = en_data_memory & ~reset;
   assign load_flags       = en_flags & ~reset;
   assign load_regfile     = en_regfile & ~reset;
   assign load_pc          = en_pc & ~reset;
   assign write_mem        = en_write_mem & ~reset;
   assign halted           = in_halt & ~reset;

endmodule
